// File: rtl/dekatron_step_sequencer.sv
// Multi-step dekatron guide-pulse sequencer: emits N two-phase steps in either
// direction, tracks tube position modulo POSITIONS and reports wrap and completion.
module dekatron_step_sequencer #(
  parameter int unsigned POSITIONS    = 10,
  parameter int unsigned POS_W        = 4,
  parameter int unsigned STEP_W       = 4,
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned INIT_POS     = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic              Reverse,
  input  logic [STEP_W-1:0] Steps,
  input  logic              Abort,
  input  logic              LoadPos,
  input  logic [POS_W-1:0]  LoadVal,
  output logic              Ready,
  output logic              Done,
  output logic              Aborted,
  output logic              PulseRight_n,
  output logic              PulseLeft_n,
  output logic [POS_W-1:0]  Position,
  output logic              Carry,
  output logic              Borrow
);

  localparam int unsigned CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POSITIONS - 1);
  localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH_A = 2'd1,
    PH_B = 2'd2,
    GAP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                dir_q, dir_d;
  logic                abort_q, abort_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                right_n_q, right_n_d;
  logic                left_n_q, left_n_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;
  logic                cnt_last;
  logic                a_low, b_low;

  assign cnt_last = (cnt_q == CNT_LAST);

  // State register and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      steps_q   <= '0;
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
      pos_q     <= POS_INIT;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      right_n_q <= 1'b1;
      left_n_q  <= 1'b1;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      steps_q   <= steps_d;
      dir_q     <= dir_d;
      abort_q   <= abort_d;
      pos_q     <= pos_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      right_n_q <= right_n_d;
      left_n_q  <= left_n_d;
      carry_q   <= carry_d;
      borrow_q  <= borrow_d;
    end
  end

  // Next-state logic; outputs are precomputed from the next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    steps_d   = steps_q;
    dir_d     = dir_q;
    abort_d   = abort_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    carry_d   = 1'b0;
    borrow_d  = 1'b0;

    if ((state_q != IDLE) && Abort) begin
      abort_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (LoadPos) begin
          pos_d = (32'(LoadVal) >= 32'(POSITIONS)) ? POS_LAST : LoadVal;
        end
        if (Req) begin
          dir_d   = Reverse;
          steps_d = Steps;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (Steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = PH_A;
          end
        end
      end
      PH_A: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = PH_B;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_B: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          steps_d = steps_q - STEP_W'(1);
          // The step has landed on the next cathode; move Position and flag wrap
          if (dir_q) begin
            if (pos_q == '0) begin
              pos_d    = POS_LAST;
              borrow_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end else begin
            if (pos_q == POS_LAST) begin
              pos_d   = '0;
              carry_d = 1'b1;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end
          if (steps_q == STEP_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            abort_d = 1'b0;
          end else if (abort_d) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
            abort_d   = 1'b0;
          end else begin
            state_d = PH_A;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    // One guide low at most: PH_A and PH_B are exclusive states
    a_low     = (state_d == PH_A);
    b_low     = (state_d == PH_B);
    right_n_d = !(dir_d ? b_low : a_low);
    left_n_d  = !(dir_d ? a_low : b_low);
    ready_d   = (state_d == IDLE);
  end

  assign Ready        = ready_q;
  assign Done         = done_q;
  assign Aborted      = aborted_q;
  assign PulseRight_n = right_n_q;
  assign PulseLeft_n  = left_n_q;
  assign Position     = pos_q;
  assign Carry        = carry_q;
  assign Borrow       = borrow_q;

endmodule

// File: doc/dekatron_step_sequencer.md
Name: dekatron_step_sequencer

Overview:
- Multi-step, parametrised successor of the single-step dekatron pulse driver.
- Accepts a request for N steps in either direction and emits the two-phase guide-pulse sequence for each step, with programmable phase duration.
- Tracks tube position modulo POSITIONS and flags wrap-around (Carry/Borrow).
- Sits between counter/control logic and the dekatron guide-electrode drivers; returns a Ready/Done handshake.

Parameters:
POSITIONS, 10, cathode count of the tube (>=2)
POS_W, 4, width of Position/LoadVal (>= clog2(POSITIONS))
STEP_W, 4, width of Steps request field
PHASE_CYCLES, 4, clocks each pulse/gap phase is held (>=1)
INIT_POS, 0, Position value after reset (<POSITIONS)

Ports:
Clk  in  1  clock
Rst_n  in  1  reset, asynchronous, active-low
Req  in  1  start request; accepted when Req & Ready
Reverse  in  1  direction for the accepted request (1 = decrement)
Steps  in  STEP_W  number of steps for the accepted request
Abort  in  1  stop after the step in progress
LoadPos  in  1  overwrite Position with LoadVal (idle only)
LoadVal  in  POS_W  value for LoadPos
Ready  out  1  high in IDLE
Done  out  1  one-cycle pulse on request completion
Aborted  out  1  qualifies Done: request ended early by Abort
PulseRight_n  out  1  guide-1 drive, active low
PulseLeft_n  out  1  guide-2 drive, active low
Position  out  POS_W  current tube position
Carry  out  1  one-cycle pulse, forward wrap POSITIONS-1 -> 0
Borrow  out  1  one-cycle pulse, reverse wrap 0 -> POSITIONS-1

Behaviour:
- Reset (async):
  - PulseRight_n = PulseLeft_n = 1.
  - Position = INIT_POS; Ready = 1.
  - Done = Aborted = Carry = Borrow = 0; state IDLE.
  - Reset mid-sequence drops pulses immediately.
- All outputs are registered. Both pulse outputs are never low together; the state encoding makes this unreachable.
- States: IDLE, PH_A, PH_B, GAP.
- Step shape:
  - Forward: PH_A = Right low, PH_B = Left low, GAP = both high.
  - Reverse: PH_A = Left low, PH_B = Right low, GAP = both high.
  - Each phase lasts exactly PHASE_CYCLES clocks. One step = 3*PHASE_CYCLES clocks.
- Accept: cycle 0 with Req & Ready.
  - Reverse and Steps are latched; Ready drops at cycle 1.
  - If Steps > 0, PH_A outputs are visible from cycle 1.
- Step k (1-based) occupies cycles 3P(k-1)+1 .. 3Pk, where P = PHASE_CYCLES.
- Position update:
  - Position changes by ±1 mod POSITIONS, visible at cycle 3Pk+1.
  - Carry/Borrow pulse in that same cycle on wrap.
- After step N: Done = 1 and Ready = 1 at cycle 3PN+1, state IDLE. A new Req may be accepted in that cycle.
- Steps = 0: no pulses; Done at cycle 1; Position unchanged.
- Abort:
  - Sampled while not IDLE; sticky until the current step's GAP ends.
  - The step in progress always completes, so the tube is never left between cathodes.
  - Then Done = 1, with Aborted = 1 only if steps remained.
  - Abort during the final step gives normal completion with Aborted = 0.
  - Abort in IDLE, including the accept cycle, is ignored.
- Req while busy: ignored, no queueing.
- LoadPos:
  - Honoured only in IDLE; Position = LoadVal next cycle. LoadVal >= POSITIONS is reduced to POSITIONS-1.
  - Ignored while busy.
  - LoadPos and Req in the same IDLE cycle: load applies first; steps count from LoadVal.
- Done, Carry and Borrow are single-cycle pulses. Aborted is valid only with Done.

Test Plan:
1. Reset, then idle 10 cycles -> Right_n = Left_n = 1, Position = 0, Ready = 1, Done = 0 throughout.
2. P=2, Position 0, Req Steps=3 Reverse=0 at cycle 0 -> Right_n low cycles 1-2, Left_n low 3-4, gap 5-6, repeating; Position 1/2/3 at cycles 7/13/19; Done + Ready at cycle 19; never both low.
3. P=2, Position 0, Steps=2 Reverse=1 -> Left_n low cycles 1-2 before Right_n 3-4; Position 9 with Borrow=1 at cycle 7; Position 8 with Done at cycle 13.
4. LoadPos LoadVal=9 together with Req Steps=1 forward, P=1 -> Position 9 then 0 at cycle 4 with Carry=1 and Done=1.
5. P=2, Steps=5, Abort pulsed at cycle 9 (step 2) -> step 2 completes; Position +2 at cycle 13; Done=1 and Aborted=1 at cycle 13; no further pulses.
6. Steps=0 -> Done at cycle 1, no pulses. Req and LoadPos during a busy sequence -> ignored, Position follows steps only. Rst_n low mid-PH_A -> both outputs 1 immediately, Position = INIT_POS.
